// File: rtl/multicycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer_pkg
//  Description : Shared definitions for the multi-cycle KGP-RISC sequencer:
//                state encoding, parameter defaults, instruction-class vector
//                bit indices and the per-state strobe decode.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_sequencer_pkg;

  localparam int DEF_CNT_W      = 32;
  localparam int DEF_WAIT_LIMIT = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_FWAIT  = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM    = 3'd5,
    ST_WB     = 3'd6
  } state_t;

  // Bit positions inside the instruction-class vector.
  localparam int CLS_ALU    = 0;
  localparam int CLS_LOAD   = 1;
  localparam int CLS_STORE  = 2;
  localparam int CLS_BRANCH = 3;
  localparam int CLS_CALL   = 4;
  localparam int CLS_RET    = 5;
  localparam int CLS_HALT   = 6;
  localparam int CLS_W      = 7;

  typedef struct packed {
    logic imem_re;
    logic flags_we;
    logic dmem_re;
    logic dmem_we;
    logic reg_we;
    logic pc_we;
    logic halted;
  } strobe_t;

  // Moore strobes for the state being entered. pc_only marks branch/ret,
  // which update the PC straight out of EXEC.
  function automatic strobe_t strobe_decode(input state_t st, input logic alu,
                                            input logic load, input logic store,
                                            input logic pc_only);
    strobe_t s;
    s = '0;
    case (st)
      ST_IDLE:            s.halted  = 1'b1;
      ST_FETCH, ST_FWAIT: s.imem_re = 1'b1;
      ST_EXEC: begin
        s.flags_we = alu;
        s.pc_we    = pc_only;
      end
      ST_MEM: begin
        s.dmem_re = load;
        s.dmem_we = store;
      end
      ST_WB: begin
        s.reg_we = 1'b1;
        s.pc_we  = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_sequencer_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer_wait_timer
//  Description : Counts consecutive wait cycles and flags the cycle on which
//                the limit is reached. Shared by the FWAIT and MEM phases.
//  Ports       : clk, reset (sync, active-low)
//                i_clear   - zero the count (takes priority)
//                i_enable  - this cycle is a not-ready wait cycle
//                o_expired - this wait cycle is the LIMIT-th in a row
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // The count never needs to hold LIMIT itself: the LIMIT-th wait cycle
  // forces a state change, which clears the timer.
  localparam int              CW     = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0]   c_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Ready on the final allowed cycle deasserts i_enable, so it wins.
  assign o_expired = i_enable && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer
//  Description : Multi-cycle control FSM for the KGP-RISC datapath. Steps
//                FETCH/FWAIT/DECODE/EXEC/MEM/WB, tolerates IMem/DMem wait
//                states, gives run/single-step/halt control and keeps cycle
//                and retired-instruction counters.
//  Ports       : clk, reset (sync, active-low)
//                i_run, i_step                 - run level / step pulse
//                i_imem_ready, i_dmem_ready    - memory handshakes
//                i_is_*                        - instruction class flags
//                o_imem_re, o_ir_we, o_flags_we, o_dmem_re, o_dmem_we,
//                o_reg_we, o_pc_we             - datapath strobes
//                o_halted, o_bus_err, o_illegal, o_state
//                o_cycle_count, o_instr_count  - CNT_W-bit counters
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WAIT_LIMIT = DEF_WAIT_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  input  logic             i_is_alu,
  input  logic             i_is_load,
  input  logic             i_is_store,
  input  logic             i_is_branch,
  input  logic             i_is_call,
  input  logic             i_is_ret,
  input  logic             i_is_halt,
  output logic             o_imem_re,
  output logic             o_ir_we,
  output logic             o_flags_we,
  output logic             o_dmem_re,
  output logic             o_dmem_we,
  output logic             o_reg_we,
  output logic             o_pc_we,
  output logic             o_halted,
  output logic             o_bus_err,
  output logic             o_illegal,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_instr_count
);

  state_t               r_state;
  strobe_t              r_strb;
  logic [CLS_HALT-1:0]  r_cls;       // halt never leaves DECODE, so not kept
  logic                 r_step;
  logic                 r_bus_err;
  logic                 r_illegal;
  logic [CNT_W-1:0]     r_cycle_cnt;
  logic [CNT_W-1:0]     r_instr_cnt;

  logic [CLS_W-1:0]     w_cls;
  state_t               w_next;
  state_t               w_retire_next;
  logic                 w_retire;
  logic                 w_set_illegal;
  logic                 w_set_bus_err;
  logic                 w_step_set;
  logic                 w_wait_en;
  logic                 w_wait_clr;
  logic                 w_expired;
  logic                 w_nx_alu;
  logic                 w_nx_load;
  logic                 w_nx_store;
  logic                 w_nx_pc_only;

  always_comb begin
    w_cls             = '0;
    w_cls[CLS_ALU]    = i_is_alu;
    w_cls[CLS_LOAD]   = i_is_load;
    w_cls[CLS_STORE]  = i_is_store;
    w_cls[CLS_BRANCH] = i_is_branch;
    w_cls[CLS_CALL]   = i_is_call;
    w_cls[CLS_RET]    = i_is_ret;
    w_cls[CLS_HALT]   = i_is_halt;
  end

  assign w_wait_en = ((r_state == ST_FWAIT) && !i_imem_ready) ||
                     ((r_state == ST_MEM)   && !i_dmem_ready);
  assign w_wait_clr = (w_next != r_state);

  multicycle_sequencer_wait_timer #(
    .LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wait_clr),
    .i_enable  (w_wait_en),
    .o_expired (w_expired)
  );

  // A single-stepped instruction always returns to IDLE once it retires.
  assign w_retire_next = (i_run && !r_step) ? ST_FETCH : ST_IDLE;

  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    w_step_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!(r_bus_err || r_illegal)) begin
          if (i_run) begin
            w_next = ST_FETCH;
          end else if (i_step) begin
            w_next     = ST_FETCH;
            w_step_set = 1'b1;
          end
        end
      end
      ST_FETCH: w_next = ST_FWAIT;
      ST_FWAIT: begin
        if (i_imem_ready) begin
          w_next = ST_DECODE;
        end else if (w_expired) begin
          w_next        = ST_IDLE;
          w_set_bus_err = 1'b1;
        end
      end
      ST_DECODE: begin
        if (!$onehot(w_cls)) begin
          w_next        = ST_IDLE;
          w_set_illegal = 1'b1;
        end else if (i_is_halt) begin
          w_next   = ST_IDLE;
          w_retire = 1'b1;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_cls[CLS_ALU] || r_cls[CLS_CALL]) begin
          w_next = ST_WB;
        end else if (r_cls[CLS_LOAD] || r_cls[CLS_STORE]) begin
          w_next = ST_MEM;
        end else begin
          w_next   = w_retire_next;
          w_retire = 1'b1;
        end
      end
      ST_MEM: begin
        if (i_dmem_ready) begin
          if (r_cls[CLS_LOAD]) begin
            w_next = ST_WB;
          end else begin
            w_next   = w_retire_next;
            w_retire = 1'b1;
          end
        end else if (w_expired) begin
          w_next        = ST_IDLE;
          w_set_bus_err = 1'b1;
        end
      end
      ST_WB: begin
        w_next   = w_retire_next;
        w_retire = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Class seen by the state being entered: EXEC is entered from DECODE and
  // must use the live flags; later phases use the latched copy.
  assign w_nx_alu     = (r_state == ST_DECODE) ? i_is_alu   : r_cls[CLS_ALU];
  assign w_nx_load    = (r_state == ST_DECODE) ? i_is_load  : r_cls[CLS_LOAD];
  assign w_nx_store   = (r_state == ST_DECODE) ? i_is_store : r_cls[CLS_STORE];
  assign w_nx_pc_only = (r_state == ST_DECODE) ? (i_is_branch | i_is_ret)
                                               : (r_cls[CLS_BRANCH] | r_cls[CLS_RET]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_strb      <= strobe_decode(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
      r_cls       <= '0;
      r_step      <= 1'b0;
      r_bus_err   <= 1'b0;
      r_illegal   <= 1'b0;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_strb  <= strobe_decode(w_next, w_nx_alu, w_nx_load, w_nx_store, w_nx_pc_only);
      if (r_state == ST_DECODE) begin
        r_cls <= w_cls[CLS_HALT-1:0];
      end
      if (w_step_set) begin
        r_step <= 1'b1;
      end else if (w_next == ST_IDLE) begin
        r_step <= 1'b0;
      end
      if (w_set_bus_err) begin
        r_bus_err <= 1'b1;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (r_state != ST_IDLE) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + 1'b1;
      end
    end
  end

  assign o_imem_re     = r_strb.imem_re;
  assign o_flags_we    = r_strb.flags_we;
  assign o_dmem_re     = r_strb.dmem_re;
  assign o_dmem_we     = r_strb.dmem_we;
  assign o_reg_we      = r_strb.reg_we;
  assign o_halted      = r_strb.halted;
  // The IR and a store's PC update must land in the very cycle the memory
  // completes, so these two are qualified by the ready inputs.
  assign o_ir_we       = (r_state == ST_FWAIT) && i_imem_ready;
  assign o_pc_we       = r_strb.pc_we ||
                         ((r_state == ST_MEM) && r_cls[CLS_STORE] && i_dmem_ready);
  assign o_bus_err     = r_bus_err;
  assign o_illegal     = r_illegal;
  assign o_state       = r_state;
  assign o_cycle_count = r_cycle_cnt;
  assign o_instr_count = r_instr_cnt;

endmodule
`default_nettype wire
